// File: rtl/dual_fetch_queue.sv
// Dual-issue fetch front end: fetches two consecutive words per cycle into a
// small FIFO and presents up to two instructions (with PC+4) to IF/ID.
module dual_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IF_ID_enable,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata0,
  input  logic [31:0] imem_rdata1,
  output logic [31:0] PC_4,
  output logic [31:0] Instrucction,
  output logic [31:0] PC_8,
  output logic [31:0] Instrucction_2,
  output logic        valid_0,
  output logic        valid_1
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_pc4   [QDEPTH];
  logic [31:0]   r_instr [QDEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_valid0;
  logic          w_valid1;
  logic          w_push;
  logic [1:0]    w_pop_n;
  logic [AW-1:0] w_head1;
  logic [AW-1:0] w_tail1;
  logic [31:0]   w_redirect_pc;

  // Request depends only on registered count, so a stall never reaches imem_req.
  assign imem_req  = !rst && !redirect && (r_count <= CW'(QDEPTH - 2));
  assign imem_addr = r_fetch_pc;
  assign w_push    = imem_req && imem_ready;

  assign w_valid0  = (r_count != '0) && !redirect && !rst;
  assign w_valid1  = (r_count >= CW'(2)) && !redirect && !rst;
  assign w_pop_n   = IF_ID_enable ? 2'd0 : ({1'b0, w_valid0} + {1'b0, w_valid1});

  assign w_head1       = r_head + AW'(1);
  assign w_tail1       = r_tail + AW'(1);
  assign w_redirect_pc = redirect_pc & ~32'd3;

  assign valid_0        = w_valid0;
  assign valid_1        = w_valid1;
  assign PC_4           = w_valid0 ? r_pc4[r_head]    : 32'h0;
  assign Instrucction   = w_valid0 ? r_instr[r_head]  : 32'h0;
  assign PC_8           = w_valid1 ? r_pc4[w_head1]   : 32'h0;
  assign Instrucction_2 = w_valid1 ? r_instr[w_head1] : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else if (redirect) begin
      r_fetch_pc <= w_redirect_pc;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_fetch_pc <= r_fetch_pc + 32'd8;
        r_tail     <= r_tail + AW'(2);
      end
      r_head  <= r_head + AW'(w_pop_n);
      r_count <= r_count + (w_push ? CW'(2) : CW'(0)) - CW'(w_pop_n);
    end
  end

  // Storage needs no reset: entries are only visible once counted as valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc4[r_tail]    <= r_fetch_pc + 32'd4;
      r_instr[r_tail]  <= imem_rdata0;
      r_pc4[w_tail1]   <= r_fetch_pc + 32'd8;
      r_instr[w_tail1] <= imem_rdata1;
    end
  end

endmodule
